// File: rtl/pmu_seq_if.sv
// Request/status bundle between the register domain, eFuse loader, clock/reset unit and pmu_seq.
// master is the sequencer side; slave is the environment side.
interface pmu_seq_if;
  logic       rg_top_start;
  logic       efuse_done;
  logic       fifo_flush_req;
  logic       timer_clk_en;
  logic       data_clk_en;
  logic       afe_clk_en;
  logic       slot_clk_en;
  logic       shut_rstn;
  logic       pmu_fifo_rstn;
  logic       efuse_load_state;
  logic       efuse_err;
  logic [2:0] pmu_state;

  modport master (
    input  rg_top_start, efuse_done, fifo_flush_req,
    output timer_clk_en, data_clk_en, afe_clk_en, slot_clk_en,
           shut_rstn, pmu_fifo_rstn, efuse_load_state, efuse_err, pmu_state
  );

  modport slave (
    output rg_top_start, efuse_done, fifo_flush_req,
    input  timer_clk_en, data_clk_en, afe_clk_en, slot_clk_en,
           shut_rstn, pmu_fifo_rstn, efuse_load_state, efuse_err, pmu_state
  );
endinterface

// File: rtl/pmu_seq.sv
// Always-on 32 kHz power sequencer: eFuse load, shutdown-domain power up/down, timed FIFO flush resets.
// All outputs registered, inputs 2-flop synchronised; PMU_SEQ_EFUSE_TIMEOUT_EN adds an eFuse load timeout.
module pmu_seq #(
  parameter int WAKE_DLY      = 4,
  parameter int OFF_DLY       = 2,
  parameter int FIFO_RST_CYC  = 3,
  parameter int EFUSE_TIMEOUT = 64
) (
  input  logic      clk_32k,
  input  logic      rst_32k_alon,
  pmu_seq_if.master bus
);
  localparam int MAX_A = (WAKE_DLY > OFF_DLY) ? WAKE_DLY : OFF_DLY;
  localparam int MAX_B = (FIFO_RST_CYC > EFUSE_TIMEOUT) ? FIFO_RST_CYC : EFUSE_TIMEOUT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_EFUSE = 3'd1,
    ST_IDLE  = 3'd2,
    ST_PWRUP = 3'd3,
    ST_RUN   = 3'd4,
    ST_PWRDN = 3'd5
  } state_t;

  logic [1:0]    start_sync, efuse_sync, flush_sync;
  logic          flush_d;
  logic          start_s, efuse_done_s, fifo_flush_req_s, flush_rise;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timer_en, timer_en_nxt, data_en, data_en_nxt;
  logic          afe_en, afe_en_nxt, slot_en, slot_en_nxt;
  logic          shut_rstn_q, shut_rstn_nxt;
  logic          efuse_load, efuse_load_nxt;
  logic          fifo_rstn;
  logic [CW-1:0] flush_cnt;

`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
  logic [CW-1:0] efuse_cnt, efuse_cnt_nxt;
  logic          efuse_err_q, efuse_err_nxt;
`endif

  always_ff @(posedge clk_32k) begin
    if (rst_32k_alon) begin
      start_sync <= '0;
      efuse_sync <= '0;
      flush_sync <= '0;
      flush_d    <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], bus.rg_top_start};
      efuse_sync <= {efuse_sync[0], bus.efuse_done};
      flush_sync <= {flush_sync[0], bus.fifo_flush_req};
      flush_d    <= fifo_flush_req_s;
    end
  end

  assign start_s          = start_sync[1];
  assign efuse_done_s     = efuse_sync[1];
  assign fifo_flush_req_s = flush_sync[1];
  assign flush_rise       = fifo_flush_req_s & ~flush_d;

  always_ff @(posedge clk_32k) begin
    if (rst_32k_alon) begin
      state       <= ST_RST;
      cnt         <= '0;
      timer_en    <= 1'b0;
      data_en     <= 1'b0;
      afe_en      <= 1'b0;
      slot_en     <= 1'b0;
      shut_rstn_q <= 1'b0;
      efuse_load  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      timer_en    <= timer_en_nxt;
      data_en     <= data_en_nxt;
      afe_en      <= afe_en_nxt;
      slot_en     <= slot_en_nxt;
      shut_rstn_q <= shut_rstn_nxt;
      efuse_load  <= efuse_load_nxt;
    end
  end

`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
  always_ff @(posedge clk_32k) begin
    if (rst_32k_alon) begin
      efuse_cnt   <= '0;
      efuse_err_q <= 1'b0;
    end else begin
      efuse_cnt   <= efuse_cnt_nxt;
      efuse_err_q <= efuse_err_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    timer_en_nxt   = timer_en;
    data_en_nxt    = data_en;
    afe_en_nxt     = afe_en;
    slot_en_nxt    = slot_en;
    shut_rstn_nxt  = shut_rstn_q;
    efuse_load_nxt = efuse_load;
`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
    efuse_cnt_nxt  = efuse_cnt;
    efuse_err_nxt  = efuse_err_q;
`endif
    case (state)
      ST_RST: begin
        state_nxt      = ST_EFUSE;
        efuse_load_nxt = 1'b1;
`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
        efuse_cnt_nxt  = CW'(EFUSE_TIMEOUT - 1);
`endif
      end
      ST_EFUSE: begin
        if (efuse_done_s) begin
          state_nxt      = ST_IDLE;
          efuse_load_nxt = 1'b0;
        end
`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
        else if (efuse_cnt == '0) begin
          state_nxt      = ST_IDLE;
          efuse_load_nxt = 1'b0;
          efuse_err_nxt  = 1'b1;
        end else begin
          efuse_cnt_nxt  = efuse_cnt - CW'(1);
        end
`endif
      end
      ST_IDLE: begin
        if (start_s) begin
          state_nxt     = ST_PWRUP;
          shut_rstn_nxt = 1'b1;
          cnt_nxt       = CW'(WAKE_DLY - 1);
        end
      end
      ST_PWRUP: begin
        // A dropped request aborts the wake before any clock is enabled.
        if (!start_s) begin
          state_nxt = ST_PWRDN;
          cnt_nxt   = CW'(OFF_DLY - 1);
        end else if (cnt == '0) begin
          state_nxt    = ST_RUN;
          afe_en_nxt   = 1'b1;
          slot_en_nxt  = 1'b1;
          timer_en_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_RUN: begin
        if (!start_s) begin
          state_nxt    = ST_PWRDN;
          cnt_nxt      = CW'(OFF_DLY - 1);
          afe_en_nxt   = 1'b0;
          slot_en_nxt  = 1'b0;
          timer_en_nxt = 1'b0;
          data_en_nxt  = 1'b0;
        end else begin
          data_en_nxt = 1'b1;
        end
      end
      ST_PWRDN: begin
        if (cnt == '0) begin
          state_nxt     = ST_IDLE;
          shut_rstn_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

  // Flush pulse runs on its own counter so FSM transitions never cut it short.
  always_ff @(posedge clk_32k) begin
    if (rst_32k_alon) begin
      fifo_rstn <= 1'b0;
      flush_cnt <= '0;
    end else if (state == ST_RST || state == ST_EFUSE) begin
      fifo_rstn <= (state_nxt == ST_IDLE);
      flush_cnt <= '0;
    end else if (flush_rise) begin
      fifo_rstn <= 1'b0;
      flush_cnt <= CW'(FIFO_RST_CYC - 1);
    end else if (!fifo_rstn) begin
      if (flush_cnt == '0) fifo_rstn <= 1'b1;
      else                 flush_cnt <= flush_cnt - CW'(1);
    end
  end

  assign bus.timer_clk_en     = timer_en;
  assign bus.data_clk_en      = data_en;
  assign bus.afe_clk_en       = afe_en;
  assign bus.slot_clk_en      = slot_en;
  assign bus.shut_rstn        = shut_rstn_q;
  assign bus.pmu_fifo_rstn    = fifo_rstn;
  assign bus.efuse_load_state = efuse_load;
  assign bus.pmu_state        = state;
`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
  assign bus.efuse_err        = efuse_err_q;
`else
  assign bus.efuse_err        = 1'b0;
`endif
endmodule

// File: tb/tb_pmu_seq.sv
// Directed bench for pmu_seq: stimulus pushes expected output changes (cycle, value) into a queue,
// a negedge monitor pops and compares every change of the output vector.
`timescale 1ns/1ps
module tb_pmu_seq;
  logic clk_32k      = 1'b0;
  logic rst_32k_alon = 1'b1;

  pmu_seq_if bus();

  pmu_seq #(
    .WAKE_DLY     (4),
    .OFF_DLY      (2),
    .FIFO_RST_CYC (3),
    .EFUSE_TIMEOUT(64)
  ) dut (
    .clk_32k      (clk_32k),
    .rst_32k_alon (rst_32k_alon),
    .bus          (bus)
  );

  always #5 clk_32k = ~clk_32k;

  typedef struct packed {
    logic [2:0] st;
    logic       err;
    logic       efl;
    logic       frst;
    logic       shut;
    logic       slot;
    logic       afe;
    logic       data;
    logic       timer;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } ev_t;

  ev_t  sb[$];
  ev_t  e;
  obs_t cur, prev, m;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  assign cur = {bus.pmu_state, bus.efuse_err, bus.efuse_load_state, bus.pmu_fifo_rstn,
                bus.shut_rstn, bus.slot_clk_en, bus.afe_clk_en, bus.data_clk_en, bus.timer_clk_en};

  always @(posedge clk_32k) cyc <= cyc + 1;

  always @(negedge clk_32k) begin
    if (armed && cur !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h (no change expected)", cyc, cur);
      end else begin
        e = sb.pop_front();
        if (e.v !== cur || e.cyc != cyc) begin
          errors++;
          $display("FAIL out_change got cyc=%0d val=%h, want cyc=%0d val=%h", cyc, cur, e.cyc, e.v);
        end
      end
      prev = cur;
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk_32k);
  endtask

  task automatic push(input int c, input obs_t v);
    ev_t x;
    x.cyc = c;
    x.v   = v;
    sb.push_back(x);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rg_top_start   = 1'b0;
    bus.efuse_done     = 1'b0;
    bus.fifo_flush_req = 1'b0;

    // Reset held over edges 1..3.
    at_cyc(3);
    checks++;
    if (cur !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", cur, 11'h0);
    end
    prev  = cur;
    armed = 1'b1;
    m     = '0;
    rst_32k_alon = 1'b0;
    m.st = 3'd1; m.efl = 1'b1; push(4, m);

    // eFuse done sampled at edge 13 -> IDLE visible at 15.
    at_cyc(12);
    bus.efuse_done = 1'b1;
    m.st = 3'd2; m.efl = 1'b0; m.frst = 1'b1; push(15, m);

    // Power up: shut_rstn +3, AFE/slot/timer +7, data +8.
    at_cyc(20);
    bus.rg_top_start = 1'b1;
    m.st = 3'd3; m.shut = 1'b1; push(23, m);
    m.st = 3'd4; m.afe = 1'b1; m.slot = 1'b1; m.timer = 1'b1; push(27, m);
    m.data = 1'b1; push(28, m);

    // Two flush edges two cycles apart in RUN: low for 43..47.
    at_cyc(40);
    bus.fifo_flush_req = 1'b1;
    m.frst = 1'b0; push(43, m);
    m.frst = 1'b1; push(48, m);
    at_cyc(41); bus.fifo_flush_req = 1'b0;
    at_cyc(42); bus.fifo_flush_req = 1'b1;
    at_cyc(43); bus.fifo_flush_req = 1'b0;

    // Power down: enables off +3, shut_rstn low and IDLE +5.
    at_cyc(60);
    bus.rg_top_start = 1'b0;
    m.st = 3'd5; m.afe = 1'b0; m.slot = 1'b0; m.timer = 1'b0; m.data = 1'b0; push(63, m);
    m.st = 3'd2; m.shut = 1'b0; push(65, m);

    // Short start pulse: PWRUP aborts to PWRDN, no enable ever rises.
    at_cyc(80);
    bus.rg_top_start = 1'b1;
    m.st = 3'd3; m.shut = 1'b1; push(83, m);
    m.st = 3'd5; push(87, m);
    m.st = 3'd2; m.shut = 1'b0; push(89, m);
    at_cyc(84); bus.rg_top_start = 1'b0;

    // Single flush edge in IDLE: low exactly 3 cycles.
    at_cyc(100);
    bus.fifo_flush_req = 1'b1;
    m.frst = 1'b0; push(103, m);
    m.frst = 1'b1; push(106, m);
    at_cyc(101); bus.fifo_flush_req = 1'b0;

    // Power up again, then reset from RUN with efuse_done still high.
    at_cyc(120);
    bus.rg_top_start = 1'b1;
    m.st = 3'd3; m.shut = 1'b1; push(123, m);
    m.st = 3'd4; m.afe = 1'b1; m.slot = 1'b1; m.timer = 1'b1; push(127, m);
    m.data = 1'b1; push(128, m);
    at_cyc(135);
    rst_32k_alon = 1'b1;
    bus.rg_top_start = 1'b0;
    m = '0; push(136, m);
    at_cyc(137);
    rst_32k_alon = 1'b0;
    m.st = 3'd1; m.efl = 1'b1; push(138, m);
    m.st = 3'd2; m.efl = 1'b0; m.frst = 1'b1; push(140, m);

`ifdef PMU_SEQ_EFUSE_TIMEOUT_EN
    // No efuse_done: IDLE with efuse_err 64 cycles after entering EFUSE, cleared by reset.
    at_cyc(150);
    rst_32k_alon = 1'b1;
    bus.efuse_done = 1'b0;
    m = '0; push(151, m);
    at_cyc(152);
    rst_32k_alon = 1'b0;
    m.st = 3'd1; m.efl = 1'b1; push(153, m);
    m.st = 3'd2; m.efl = 1'b0; m.frst = 1'b1; m.err = 1'b1; push(217, m);
    at_cyc(230);
    rst_32k_alon = 1'b1;
    m = '0; push(231, m);
    at_cyc(232);
    rst_32k_alon = 1'b0;
    m.st = 3'd1; m.efl = 1'b1; push(233, m);
    at_cyc(240);
`else
    at_cyc(150);
`endif

    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change got none by cyc=%0d, want cyc=%0d val=%h", cyc, e.cyc, e.v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
